// File: rtl/mod_control_pipe.sv
// mod_control_pipe: main control decoder registered at the ID/EX boundary.
// It decodes each instruction into an 18-bit control word and presents that
// word one cycle later. It uses a valid/ready handshake toward decode and honours
// a downstream stall and a flush. Multi-cycle multiply/divide operations are
// sequenced here: decode is back-pressured for MD_LATENCY cycles.
//
// Ports (mod_control_pipe)
//   i_clock      rising-edge clock
//   i_reset      asynchronous, active-low reset
//   i_operation  opcode [31:26]
//   i_function   funct [5:0]
//   i_valid      instruction present at decode
//   o_ready      combinational; instruction consumed when i_valid & o_ready
//   i_stall      downstream hold, freezes the output register
//   i_flush      squash, the output register loads a bubble
//   o_control    registered control word
//   o_valid      registered; o_control carries a real instruction
//   o_md_start   one-cycle pulse in the first busy cycle
//   o_md_busy    multiply/divide in progress
//   o_md_done    one-cycle pulse after the last busy cycle
//   o_md_count   remaining busy cycles minus one (0 when not busy)
//
// Control word layout:
//   RegDst[17] MemToReg[16] MemRead[15] Branch[14] MemWrite[13] Ope[12:10]
//   ALUSrc[9] RegWrite[8] ShiftSrc[7] JmpSrc[6] JReturnDst[5] EQorNE[4]
//   DataMask[3:2] IsUnsigned[1] JmpOrBrch[0]

// mod_control: combinational main control decoder.
//   i_operation, i_function  instruction fields
//   i_enable_control         1 forces an all-zero (bubble) control word
//   o_control                decoded control word
module mod_control #(
  parameter int NB_FUNCTION = 6,
  parameter int NB_CONTROL  = 18
) (
  input  logic [NB_FUNCTION-1:0] i_operation,
  input  logic [NB_FUNCTION-1:0] i_function,
  input  logic                   i_enable_control,
  output logic [NB_CONTROL-1:0]  o_control
);

  logic [17:0] word;

  always_comb begin
    word = 18'h00000;
    case (i_operation)
      6'b000000: begin
        case (i_function)
          6'b000000, 6'b000010, 6'b000011: word = 18'h0058C; // shift by shamt
          6'b001000:                       word = 18'h0000D; // JR
          6'b001001:                       word = 18'h0012D; // JALR
          6'b011000, 6'b011001,
          6'b011010, 6'b011011:            word = 18'h0000D; // MULT/MULTU/DIV/DIVU
          default:                         word = 18'h0050C; // register ALU op
        endcase
      end
      6'b000010: word = 18'h0004C; // J
      6'b000011: word = 18'h0016C; // JAL
      6'b000100: word = 18'h0404C; // BEQ
      6'b000101: word = 18'h0405C; // BNE
      6'b001000: word = 18'h20B0C; // ADDI
      6'b001001: word = 18'h20B0E; // ADDIU
      6'b001010: word = 18'h21F0C; // SLTI
      6'b001011: word = 18'h21F0E; // SLTIU
      6'b001100: word = 18'h20F0E; // ANDI (zero-extended immediate)
      6'b001101: word = 18'h2130E; // ORI
      6'b001110: word = 18'h2170E; // XORI
      6'b001111: word = 18'h21B0C; // LUI
      6'b100000: word = 18'h38300; // LB
      6'b100001: word = 18'h38304; // LH
      6'b100011: word = 18'h3830C; // LW
      6'b100100: word = 18'h38302; // LBU
      6'b100101: word = 18'h38306; // LHU
      6'b100111: word = 18'h3830E; // LWU
      6'b101000: word = 18'h02200; // SB
      6'b101001: word = 18'h02204; // SH
      6'b101011: word = 18'h0220C; // SW
      default:   word = 18'h00000;
    endcase
    if (i_enable_control) begin
      word = 18'h00000;
    end
  end

  assign o_control = NB_CONTROL'(word);

endmodule

module mod_control_pipe #(
  parameter int NB_FUNCTION = 6,
  parameter int NB_CONTROL  = 18,
  parameter int MD_LATENCY  = 4,
  parameter int NB_COUNT    = 3
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic [NB_FUNCTION-1:0] i_operation,
  input  logic [NB_FUNCTION-1:0] i_function,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic                   i_stall,
  input  logic                   i_flush,
  output logic [NB_CONTROL-1:0]  o_control,
  output logic                   o_valid,
  output logic                   o_md_start,
  output logic                   o_md_busy,
  output logic                   o_md_done,
  output logic [NB_COUNT-1:0]    o_md_count
);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  localparam logic [NB_COUNT-1:0] COUNT_LOAD = NB_COUNT'(MD_LATENCY - 1);

  md_state_t             state_q;
  logic [NB_COUNT-1:0]   count_q;
  logic                  md_start_q;
  logic                  md_done_q;
  logic [NB_CONTROL-1:0] control_q;
  logic [NB_CONTROL-1:0] control_d;
  logic                  valid_q;
  logic                  valid_d;
  logic [NB_CONTROL-1:0] dec_control;
  logic                  accept;
  logic                  is_md;
  logic                  md_issue;

  mod_control #(
    .NB_FUNCTION (NB_FUNCTION),
    .NB_CONTROL  (NB_CONTROL)
  ) u_decode (
    .i_operation      (i_operation),
    .i_function       (i_function),
    .i_enable_control (1'b0),
    .o_control        (dec_control)
  );

  assign o_ready  = ~i_stall & (state_q != MD_BUSY);
  assign accept   = i_valid & o_ready;
  assign is_md    = (i_operation == '0) & (i_function[5:2] == 4'b0110);
  // A flushed accept is consumed and discarded, so it must not issue.
  assign md_issue = accept & ~i_flush & is_md;

  // Stall beats flush; flush beats accept.
  always_comb begin
    control_d = control_q;
    valid_d   = valid_q;
    if (!i_stall) begin
      if (i_flush) begin
        control_d = '0;
        valid_d   = 1'b0;
      end else if (accept) begin
        control_d = dec_control;
        valid_d   = 1'b1;
      end else begin
        control_d = '0;
        valid_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      control_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      control_q <= control_d;
      valid_q   <= valid_d;
    end
  end

  // Once issued, an operation runs to completion regardless of stall/flush.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= MD_IDLE;
      count_q    <= '0;
      md_start_q <= 1'b0;
      md_done_q  <= 1'b0;
    end else begin
      md_start_q <= 1'b0;
      md_done_q  <= 1'b0;
      case (state_q)
        MD_IDLE: begin
          if (md_issue) begin
            state_q    <= MD_BUSY;
            count_q    <= COUNT_LOAD;
            md_start_q <= 1'b1;
          end
        end
        MD_BUSY: begin
          if (count_q == '0) begin
            state_q   <= MD_DONE;
            md_done_q <= 1'b1;
          end else begin
            count_q <= count_q - 1'b1;
          end
        end
        MD_DONE: begin
          if (md_issue) begin
            state_q    <= MD_BUSY;
            count_q    <= COUNT_LOAD;
            md_start_q <= 1'b1;
          end else begin
            state_q <= MD_IDLE;
          end
        end
        default: begin
          state_q <= MD_IDLE;
          count_q <= '0;
        end
      endcase
    end
  end

  assign o_control  = control_q;
  assign o_valid    = valid_q;
  assign o_md_start = md_start_q;
  assign o_md_busy  = (state_q == MD_BUSY);
  assign o_md_done  = md_done_q;
  // The counter has already reached 0 before leaving MD_BUSY, so it reads 0 elsewhere.
  assign o_md_count = count_q;

endmodule
